// File: rtl/vme_master_cycle.sv
// Single-word A24/D16 VME bus-cycle initiator with 2-flop DTACK/BERR synchronizers.
// Optional wait-state timeout is compiled in with `define VME_MASTER_TIMEOUT_EN.
module vme_master_cycle #(
  parameter int ADR_SETUP = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        FASTCLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WRITE,
  input  logic [22:0] REQ_ADR,
  input  logic [5:0]  REQ_AM,
  input  logic [15:0] REQ_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RD_DATA,
  output logic [22:0] ADR,
  output logic [5:0]  AM,
  output logic        AS_B,
  output logic        DS0_B,
  output logic        DS1_B,
  output logic        LWORD_B,
  output logic        WRITE_B,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  input  logic        DTACK_B,
  input  logic        BERR_B
);

  typedef enum logic [2:0] {IDLE, SETUP, ASTB, DSTB, WACK, REL, WREL, FIN} state_t;

  state_t      state;
  logic [1:0]  dtk_sync, berr_sync;
  logic        dtk_s, berr_s;
  logic [7:0]  setup_cnt;
  logic        err_r;
  logic        tmo_hit;

  assign LWORD_B = 1'b1;
  assign dtk_s   = dtk_sync[1];
  assign berr_s  = berr_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      dtk_sync  <= 2'b00;
      berr_sync <= 2'b00;
    end else begin
      dtk_sync  <= {dtk_sync[0], ~DTACK_B};
      berr_sync <= {berr_sync[0], ~BERR_B};
    end
  end

`ifdef VME_MASTER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;

  assign tmo_nxt = tmo_cnt + 8'd1;
  assign tmo_hit = (tmo_nxt == 8'(TIMEOUT));

  // Runs only in the two wait states; every other state holds it cleared.
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST)                                tmo_cnt <= 8'd0;
    else if (state == WACK || state == WREL) tmo_cnt <= tmo_nxt;
    else                                    tmo_cnt <= 8'd0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ADR       <= '0;
      AM        <= '0;
      D_OUT     <= '0;
      RD_DATA   <= '0;
      AS_B      <= 1'b1;
      DS0_B     <= 1'b1;
      DS1_B     <= 1'b1;
      WRITE_B   <= 1'b1;
      D_OE      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      err_r     <= 1'b0;
      setup_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ) begin
            ADR       <= REQ_ADR;
            AM        <= REQ_AM;
            D_OUT     <= REQ_DATA;
            WRITE_B   <= ~REQ_WRITE;
            D_OE      <= REQ_WRITE;
            BUSY      <= 1'b1;
            err_r     <= 1'b0;
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == 8'(ADR_SETUP - 1)) begin
            AS_B  <= 1'b0;
            state <= ASTB;
          end else begin
            setup_cnt <= setup_cnt + 8'd1;
          end
        end
        ASTB: begin
          DS0_B <= 1'b0;
          DS1_B <= 1'b0;
          state <= DSTB;
        end
        DSTB: state <= WACK;
        WACK: begin
          // BERR is checked first so it wins over a simultaneous DTACK.
          if (berr_s || dtk_s || tmo_hit) begin
            if (berr_s || tmo_hit) begin
              err_r <= 1'b1;
            end else begin
              err_r <= 1'b0;
              if (WRITE_B) RD_DATA <= D_IN;
            end
            AS_B  <= 1'b1;
            DS0_B <= 1'b1;
            DS1_B <= 1'b1;
            D_OE  <= 1'b0;
            state <= REL;
          end
        end
        REL: state <= WREL;
        WREL: begin
          if ((!dtk_s && !berr_s) || tmo_hit) begin
            DONE  <= 1'b1;
            ERR   <= err_r | (tmo_hit & (dtk_s | berr_s));
            BUSY  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          DONE    <= 1'b0;
          ERR     <= 1'b0;
          WRITE_B <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_master_cycle.sv
// Directed bench for vme_master_cycle: scoreboard of expected DONE status/read data,
// plus timing checks on strobes around a scripted slave.
module tb_vme_master_cycle;

  localparam int ADR_SETUP = 2;
  localparam int TIMEOUT   = 20;

  logic        FASTCLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0, REQ_WRITE = 1'b0;
  logic [22:0] REQ_ADR = '0;
  logic [5:0]  REQ_AM = '0;
  logic [15:0] REQ_DATA = '0;
  logic        BUSY, DONE, ERR;
  logic [15:0] RD_DATA;
  logic [22:0] ADR;
  logic [5:0]  AM;
  logic        AS_B, DS0_B, DS1_B, LWORD_B, WRITE_B;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN = '0;
  logic        DTACK_B = 1'b1, BERR_B = 1'b1;

  vme_master_cycle #(.ADR_SETUP(ADR_SETUP), .TIMEOUT(TIMEOUT)) dut (
    .FASTCLK(FASTCLK), .RST(RST), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADR(REQ_ADR), .REQ_AM(REQ_AM), .REQ_DATA(REQ_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RD_DATA(RD_DATA),
    .ADR(ADR), .AM(AM), .AS_B(AS_B), .DS0_B(DS0_B), .DS1_B(DS1_B),
    .LWORD_B(LWORD_B), .WRITE_B(WRITE_B), .D_OUT(D_OUT), .D_OE(D_OE),
    .D_IN(D_IN), .DTACK_B(DTACK_B), .BERR_B(BERR_B)
  );

  always #5 FASTCLK = ~FASTCLK;

  typedef struct packed {
    logic        err;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   oe_cycles = 0;

  always @(negedge FASTCLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (D_OE === 1'b1) oe_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge FASTCLK);
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [22:0] a, input logic [5:0] m,
                       input logic [15:0] d, input logic push, input logic e_err,
                       input logic [15:0] e_rd);
    REQ = 1'b1; REQ_WRITE = wr; REQ_ADR = a; REQ_AM = m; REQ_DATA = d;
    if (push) sb.push_back('{err: e_err, rd: e_rd});
    tick(1);
    REQ = 1'b0;
  endtask

  task automatic wait_ds(input logic lvl, input int limit, output int n);
    n = 0;
    while (DS0_B !== lvl && n < limit) begin
      tick(1);
      n++;
    end
    check("ds_wait", 32'(DS0_B), 32'(lvl));
  endtask

  // mode 0: DTACK, 1: BERR, 2: both together
  task automatic slave_ack(input int delay, input int mode, input logic [15:0] data);
    int n;
    wait_ds(1'b0, 50, n);
    tick(delay);
    D_IN = data;
    if (mode != 1) DTACK_B = 1'b0;
    if (mode != 0) BERR_B = 1'b0;
    wait_ds(1'b1, 50, n);
    DTACK_B = 1'b1;
    BERR_B  = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    exp_t e;
    while (DONE !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, 32'(DONE), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"}, 32'(ERR), 32'(e.err));
      check({tag, "_rd_data"}, 32'(RD_DATA), 32'(e.rd));
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    int          n, d0, oe0;
    logic        unstable;
    logic [15:0] last_rd;

    tick(3);
    check("rst_strobes", 32'({AS_B, DS0_B, DS1_B, WRITE_B, LWORD_B}), 32'h1F);
    check("rst_adr_am", 32'({ADR, AM}), 32'd0);
    check("rst_data", {D_OUT, RD_DATA}, 32'd0);
    check("rst_status", 32'({D_OE, BUSY, DONE, ERR}), 32'd0);
    RST = 1'b0;
    tick(2);

    // Write; slave acknowledges 5 cycles after DS falls
    issue(1'b1, 23'h0C2001, 6'h39, 16'hA5A5, 1'b1, 1'b0, 16'h0000);
    check("wr_busy", 32'(BUSY), 32'd1);
    check("wr_bus", 32'({WRITE_B, D_OE, D_OUT}), 32'({1'b0, 1'b1, 16'hA5A5}));
    n = 0;
    unstable = 1'b0;
    while (AS_B !== 1'b0 && n < 20) begin
      if ({ADR, AM} !== {23'h0C2001, 6'h39}) unstable = 1'b1;
      tick(1);
      n++;
    end
    check("adr_setup", n, ADR_SETUP);
    check("adr_stable", 32'({unstable, ADR, AM}), 32'({1'b0, 23'h0C2001, 6'h39}));
    wait_ds(1'b0, 5, n);
    check("as_to_ds", n, 1);
    check("wr_ds_low", 32'({DS1_B, D_OE, D_OUT}), 32'({1'b0, 1'b1, 16'hA5A5}));
    tick(5);
    DTACK_B = 1'b0;
    n = 0;
    while (DS0_B !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("release_lat", n, 3);
    check("release_all", 32'({AS_B, DS1_B, D_OE, DONE}), 32'b1100);
    DTACK_B = 1'b1;
    wait_done("wr");
    last_rd = 16'h0000;

    // Read with data presented alongside DTACK
    tick(1);
    oe0 = oe_cycles;
    issue(1'b0, 23'h012345, 6'h3D, 16'h0000, 1'b1, 1'b0, 16'hBEEF);
    check("rd_write_b", 32'(WRITE_B), 32'd1);
    slave_ack(2, 0, 16'hBEEF);
    wait_done("rd");
    check("rd_no_oe", oe_cycles - oe0, 0);
    last_rd = 16'hBEEF;

    // Bus error: RD_DATA keeps the previous value
    tick(1);
    issue(1'b0, 23'h054321, 6'h3D, 16'h0000, 1'b1, 1'b1, last_rd);
    slave_ack(1, 1, 16'h1234);
    wait_done("berr");

    // DTACK and BERR together: BERR wins
    tick(1);
    issue(1'b0, 23'h054322, 6'h3D, 16'h0000, 1'b1, 1'b1, last_rd);
    slave_ack(0, 2, 16'h5678);
    wait_done("both");

`ifdef VME_MASTER_TIMEOUT_EN
    tick(1);
    issue(1'b0, 23'h300000, 6'h39, 16'h0000, 1'b1, 1'b1, last_rd);
    wait_ds(1'b0, 10, n);
    tick(1);
    n = 0;
    while (DS0_B !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check("tmo_lat", n, TIMEOUT);
    wait_done("tmo");
`else
    tick(1);
    issue(1'b0, 23'h300000, 6'h39, 16'h0000, 1'b0, 1'b0, 16'h0000);
    n = 0;
    repeat (1000) begin
      tick(1);
      if (BUSY !== 1'b1) n++;
    end
    check("hang_busy", n, 0);
    RST = 1'b1;
    #1;
    check("hang_rst_busy", 32'(BUSY), 32'd0);
    tick(1);
    RST = 1'b0;
    tick(1);
    last_rd = 16'h0000;
`endif

    // REQ pulsed during WACK is ignored; next REQ right after FIN is taken
    d0 = done_cnt;
    issue(1'b1, 23'h000100, 6'h39, 16'h1111, 1'b1, 1'b0, last_rd);
    wait_ds(1'b0, 10, n);
    tick(2);
    REQ = 1'b1; REQ_WRITE = 1'b0; REQ_ADR = 23'h7FFFFF;
    tick(1);
    REQ = 1'b0;
    check("ign_adr", 32'(ADR), 32'h000100);
    tick(3);
    DTACK_B = 1'b0;
    wait_ds(1'b1, 20, n);
    DTACK_B = 1'b1;
    wait_done("ign");
    tick(1);
    check("ign_one_done", done_cnt - d0, 1);
    issue(1'b0, 23'h000200, 6'h39, 16'h0000, 1'b1, 1'b0, 16'hC0DE);
    check("b2b_start", 32'({BUSY, ADR}), 32'({1'b1, 23'h000200}));
    slave_ack(0, 0, 16'hC0DE);
    wait_done("b2b");
    tick(5);
    check("b2b_done_count", done_cnt - d0, 2);

    // Reset while DS is low
    d0 = done_cnt;
    issue(1'b1, 23'h0ABCDE, 6'h39, 16'h2222, 1'b0, 1'b0, 16'h0000);
    wait_ds(1'b0, 10, n);
    tick(1);
    RST = 1'b1;
    #1;
    check("rst_mid", 32'({AS_B, DS0_B, DS1_B, BUSY, D_OE}), 32'b11100);
    tick(2);
    RST = 1'b0;
    tick(10);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_busy", 32'(BUSY), 32'd0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_master_cycle.md
Name: vme_master_cycle

Overview:
- Single-word A24/D16 VME bus-cycle initiator; the master side of the slave address/strobe decode in the VME interface FPGA.
- Used by the test/bridge path to issue read/write cycles to DMB-style slaves: drives ADR/AM/AS_B/DS*_B/WRITE_B, waits for DTACK_B or BERR_B, then returns read data and status to the local requester.

Parameters:
- ADR_SETUP, 2, FASTCLK cycles ADR/AM/WRITE_B are held stable before AS_B falls (minimum 1).
- TIMEOUT, 255, FASTCLK cycles allowed in each wait state before abort (8-bit counter, 1..255).

Ports:
- FASTCLK  in  1  system clock; all logic is on its rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  start request; sampled only in IDLE
- REQ_WRITE  in  1  1 = write cycle, 0 = read cycle
- REQ_ADR  in  23  VME address [23:1]
- REQ_AM  in  6  address modifier
- REQ_DATA  in  16  write data
- BUSY  out  1  cycle in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; 1 = BERR or timeout
- RD_DATA  out  16  captured read data
- ADR  out  23  VME address lines
- AM  out  6  VME address modifier
- AS_B  out  1  address strobe, active low
- DS0_B  out  1  data strobe 0, active low
- DS1_B  out  1  data strobe 1, active low
- LWORD_B  out  1  held at 1 (D16 only)
- WRITE_B  out  1  0 = write
- D_OUT  out  16  write data to the bus transceiver
- D_OE  out  1  bus data output enable
- D_IN  in  16  bus data in
- DTACK_B  in  1  asynchronous slave acknowledge, active low
- BERR_B  in  1  asynchronous bus error, active low

Behaviour:
- Reset values: AS_B, DS0_B, DS1_B, WRITE_B and LWORD_B = 1; ADR, AM, D_OUT and RD_DATA = 0; D_OE, BUSY, DONE and ERR = 0. The FSM goes to IDLE.
- Reset mid-cycle releases all strobes immediately (asynchronous) and sets no status.
- DTACK_B and BERR_B pass through 2-flop synchronizers (dtk_s, berr_s, active-high internally). This adds 2 cycles of latency.
- States: IDLE, SETUP, ASTB, DSTB, WACK, REL, WREL, FIN.
- IDLE: on REQ=1, register ADR, AM, D_OUT and WRITE_B=~REQ_WRITE; go to SETUP.
  - BUSY=1 from the next cycle until FIN.
  - REQ outside IDLE is ignored, with no queueing.
- SETUP: hold for ADR_SETUP cycles. D_OE=1 during the whole cycle for writes only. Then go to ASTB.
- ASTB: AS_B=0 for 1 cycle, then go to DSTB.
- DSTB: DS0_B=DS1_B=0 (both together); clear the timeout counter; go to WACK.
- WACK: the counter increments each cycle.
  - dtk_s=1: on a read, RD_DATA<=D_IN; err_r=0; go to REL.
  - berr_s=1: err_r=1; go to REL. If both dtk_s and berr_s are set in the same cycle, BERR wins.
  - Counter==TIMEOUT (with the optional feature compiled in): err_r=1; go to REL.
  - RD_DATA is unchanged on error.
- REL: DS0_B=DS1_B=1 and AS_B=1 in the same cycle; D_OE=0; clear the counter; go to WREL.
- WREL: wait for dtk_s=0 and berr_s=0, then go to FIN. A timeout here also goes to FIN with err_r=1.
- FIN: DONE=1 and ERR=err_r for exactly 1 cycle; BUSY=0 in this cycle; go to IDLE.
- A new REQ is accepted in the cycle after FIN, so back-to-back cycles are possible.
- Best-case latency from REQ to DONE, with DTACK already low at DSTB: 1 + ADR_SETUP + 1 + 1 + 2 (sync) + 1 + 2 + 1 cycles.

Optional Feature:
- Macro: VME_MASTER_TIMEOUT_EN.
- Defined: the 8-bit counter aborts WACK and WREL after TIMEOUT cycles, as described above.
- Undefined: no counter is built; WACK and WREL wait indefinitely; ERR is asserted only by BERR.

Test Plan:
- Write: REQ_WRITE=1, REQ_ADR=23'h0C2001, REQ_AM=6'h39, REQ_DATA=16'hA5A5; slave pulls DTACK_B low 5 cycles after DS falls.
  - Required: ADR/AM stable ≥2 cycles before AS_B falls; D_OE=1 and D_OUT=16'hA5A5 while DS is low.
  - Required: strobes released 3 cycles after DTACK_B falls; DONE=1 and ERR=0 after DTACK_B rises.
- Read: REQ_WRITE=0; D_IN=16'hBEEF with DTACK_B.
  - Required: RD_DATA=16'hBEEF at DONE; D_OE stays 0 throughout.
- BERR_B low instead of DTACK_B during WACK.
  - Required: strobes released; DONE=1, ERR=1; RD_DATA keeps its previous value.
- No response with TIMEOUT=20 and the macro defined.
  - Required: DS released 20 cycles after WACK entry; DONE=1, ERR=1.
  - With the macro undefined: BUSY stays 1 for 1000 cycles.
- REQ pulsed during WACK.
  - Required: ignored; exactly one DONE; the next REQ in the cycle after FIN starts a new cycle.
- RST asserted while DS is low.
  - Required: AS_B, DS0_B, DS1_B = 1 and BUSY=0 immediately; no DONE pulse.
